// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding, reset/trap vectors and next-PC selects.
package cpu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // Redirect priority: jr > jump > branch > sequential.
    function automatic npc_sel_e npc_select(input logic jr, input logic jump, input logic br);
        if (jr) begin
            return NPC_JR;
        end else if (jump) begin
            return NPC_J;
        end else if (br) begin
            return NPC_BR;
        end
        return NPC_SEQ;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC multiplexer with word-alignment check on the chosen target.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [31:0] ext_imm,
    input  logic [31:0] jr_target,
    input  npc_sel_e    sel,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] br_target;
    logic [31:0] j_target;

    // Word offset; the two top immediate bits fall off the shift.
    assign br_target = pc_plus4 + (ext_imm << 2);
    assign j_target  = {pc_plus4[31:28], instr_index, 2'b00};

    // Select the target and flag any target that is not word aligned.
    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            NPC_SEQ: next_pc = pc_plus4;
            NPC_BR:  next_pc = br_target;
            NPC_J:   next_pc = j_target;
            NPC_JR:  next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction fetch handshake, instruction register and misaligned-target trap.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        branch_taken,
    input  logic [31:0] ext_imm,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        misalign,
    output logic [31:0] epc
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] epc_q;
    logic        misalign_q;

    npc_sel_e    sel;
    logic [31:0] next_pc;
    logic        misaligned;

    assign pc_plus4 = pc_q + 32'd4;
    assign sel      = npc_select(jr, jump, branch_taken);

    next_pc_sel u_next_pc_sel (
        .pc_plus4    (pc_plus4),
        .instr_index (instr_q[25:0]),
        .ext_imm     (ext_imm),
        .jr_target   (jr_target),
        .sel         (sel),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    // Fetch/execute sequencing, PC update on commit and trap capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            epc_q      <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        state_q <= FETCH;
                        if (misaligned) begin
                            pc_q       <= EXC_VECTOR;
                            epc_q      <= next_pc;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign epc         = epc_q;
    assign misalign    = misalign_q;

endmodule
